// File: rtl/line_buffer_pkg.sv
// Shared types and helpers for the multi-line video line buffer.
package line_buffer_pkg;

    // Default pixel format: 24-bit RGB.
    localparam int DEFAULT_DATA_WIDTH = 24;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

    // Line index counter width and its saturation value.
    localparam int                 Y_WIDTH = 16;
    localparam logic [Y_WIDTH-1:0] Y_MAX   = '1;

    // Slot that follows `slot` in a ring of n_slots line RAMs.
    function automatic int next_slot(input int slot, input int n_slots);
        return (slot >= n_slots - 1) ? 0 : slot + 1;
    endfunction

    // Slot that held the line k lines above the one going into `slot`.
    // k is in 1..n_slots, so a single wrap-around correction is enough.
    function automatic int prev_slot(input int slot, input int k, input int n_slots);
        int s;
        s = slot - k;
        if (s < 0) begin
            s = s + n_slots;
        end
        return s;
    endfunction

endpackage

// File: rtl/line_ram_sync.sv
// One stored video line: single write port plus one registered read port.
// A read and a write to the same address in the same cycle return the old word.
module line_ram_sync #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 640,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port.
    // NOTE: the array has no reset so it maps onto block RAM; stale contents are hidden by the row mask in the top.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; holds its value when not enabled.
    // NOTE: non-blocking assignments give read-before-write naturally: this read samples the array before the write above lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_buffer_window.sv
// Multi-line video line buffer: for every input pixel, emits a vertical column of
// NUM_LINES taps (current pixel plus the same x from the previous NUM_LINES-1 lines),
// one cycle later, with frame/line tracking, edge masking and line-overflow detection.
module line_buffer_window
    import line_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = $bits(pixel_t),
    parameter  int LINE_WIDTH = 640,
    parameter  int NUM_LINES  = 3,
    localparam int ADDR_WIDTH = $clog2(LINE_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_valid,
    input  logic                            i_sof,
    input  logic                            i_eol,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic                            o_valid,
    output logic [NUM_LINES*DATA_WIDTH-1:0] o_col,
    output logic                            o_col_full,
    output logic [ADDR_WIDTH-1:0]           o_x,
    output logic [Y_WIDTH-1:0]              o_y,
    output logic                            o_ovf
);

    localparam int N_SLOTS = NUM_LINES - 1;
    localparam int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int XCNT_W  = $clog2(LINE_WIDTH + 1);
    localparam int ROWS_W  = $clog2(NUM_LINES);

    localparam logic [XCNT_W-1:0]     X_LIMIT  = XCNT_W'(LINE_WIDTH);
    localparam logic [ROWS_W-1:0]     ROWS_MAX = ROWS_W'(N_SLOTS);
    localparam logic [ADDR_WIDTH-1:0] X_LAST   = ADDR_WIDTH'(LINE_WIDTH - 1);

    // Position/frame state. r_x may reach LINE_WIDTH, which marks an overflowing line.
    logic [XCNT_W-1:0]  r_x;
    logic [SLOT_W-1:0]  r_slot;
    logic [ROWS_W-1:0]  r_rows;
    logic [Y_WIDTH-1:0] r_y;
    logic               r_ovf;

    // Output pipeline registers.
    logic                  r_valid;
    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_lane0;
    logic [N_SLOTS-1:0]    r_lane_en;
    logic [SLOT_W-1:0]     r_lane_src [N_SLOTS];
    logic [ADDR_WIDTH-1:0] r_out_x;
    logic [Y_WIDTH-1:0]    r_out_y;

    // Effective state for the current pixel (start-of-frame overrides the counters).
    logic [XCNT_W-1:0]     w_x;
    logic [SLOT_W-1:0]     w_slot;
    logic [ROWS_W-1:0]     w_rows;
    logic [Y_WIDTH-1:0]    w_y;
    logic                  w_ovf_px;
    logic [ADDR_WIDTH-1:0] w_addr;

    // State after this pixel.
    logic [XCNT_W-1:0]  w_x_nxt;
    logic [SLOT_W-1:0]  w_slot_nxt;
    logic [ROWS_W-1:0]  w_rows_nxt;
    logic [Y_WIDTH-1:0] w_y_nxt;
    logic               w_ovf_nxt;

    // Per-lane source selection and masking (index k-1 for lane k).
    logic [N_SLOTS-1:0]    w_lane_en;
    logic [SLOT_W-1:0]     w_lane_src [N_SLOTS];
    logic [N_SLOTS-1:0]    w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd_data [N_SLOTS];

    // Resolve the pixel's position, RAM address and the state it leaves behind.
    // NOTE: every output of an always_comb gets a value on every path, here by assigning defaults first, so no latch is inferred.
    always_comb begin
        w_x    = i_sof ? '0 : r_x;
        w_slot = i_sof ? '0 : r_slot;
        w_rows = i_sof ? '0 : r_rows;
        w_y    = i_sof ? '0 : r_y;

        w_ovf_px = (w_x == X_LIMIT);
        w_addr   = w_ovf_px ? X_LAST : w_x[ADDR_WIDTH-1:0];

        w_x_nxt    = w_x;
        w_slot_nxt = w_slot;
        w_rows_nxt = w_rows;
        w_y_nxt    = w_y;
        w_ovf_nxt  = (i_sof ? 1'b0 : r_ovf) | w_ovf_px;

        if (i_eol) begin
            w_x_nxt    = '0;
            w_slot_nxt = SLOT_W'(next_slot(int'(w_slot), N_SLOTS));
            if (w_rows != ROWS_MAX) begin
                w_rows_nxt = w_rows + 1'b1;
            end
            if (w_y != Y_MAX) begin
                w_y_nxt = w_y + 1'b1;
            end
        end else if (!w_ovf_px) begin
            w_x_nxt = w_x + 1'b1;
        end
    end

    // Lane k reads the slot written k lines ago; hidden if that line is not in this frame or the pixel overflowed.
    always_comb begin
        for (int k = 1; k < NUM_LINES; k++) begin
            w_lane_en[k-1]  = !w_ovf_px && (k <= int'(w_rows));
            w_lane_src[k-1] = SLOT_W'(prev_slot(int'(w_slot), k, N_SLOTS));
        end
    end

    // Ring of line RAMs: every slot is read each pixel, only the current slot is written.
    for (genvar s = 0; s < N_SLOTS; s++) begin : g_ram
        assign w_wr_en[s] = i_valid && !w_ovf_px && (w_slot == SLOT_W'(s));

        line_ram_sync #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LINE_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_rd_en   (i_valid),
            .i_rd_addr (w_addr),
            .i_wr_en   (w_wr_en[s]),
            .i_wr_addr (w_addr),
            .i_wr_data (i_data),
            .o_rd_data (w_rd_data[s])
        );
    end

    // Advance position, slot pointer, row count, line index and overflow flag on each pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_slot <= '0;
            r_rows <= '0;
            r_y    <= '0;
            r_ovf  <= 1'b0;
        end else if (i_valid) begin
            r_x    <= w_x_nxt;
            r_slot <= w_slot_nxt;
            r_rows <= w_rows_nxt;
            r_y    <= w_y_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    // Capture the column metadata alongside the RAM reads; data holds across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_lane0    <= '0;
            r_lane_en  <= '0;
            r_lane_src <= '{default: '0};
            r_out_x    <= '0;
            r_out_y    <= '0;
        end else begin
            r_valid <= i_valid;
            r_full  <= i_valid && (w_rows == ROWS_MAX);
            if (i_valid) begin
                r_lane0    <= i_data;
                r_lane_en  <= w_lane_en;
                r_lane_src <= w_lane_src;
                r_out_x    <= w_addr;
                r_out_y    <= w_y;
            end
        end
    end

    // Assemble the output column from the registered lane0 and the registered RAM reads.
    always_comb begin
        o_col                 = '0;
        o_col[DATA_WIDTH-1:0] = r_lane0;
        for (int k = 1; k < NUM_LINES; k++) begin
            if (r_lane_en[k-1]) begin
                o_col[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[r_lane_src[k-1]];
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_col_full = r_full;
    assign o_x        = r_out_x;
    assign o_y        = r_out_y;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_line_buffer_window.sv
// Directed bench for line_buffer_window with 8-bit pixels, 8-pixel lines, 3 taps.
// Pixel data is 16*y + x, so every lane value identifies its line and column.
module tb_line_buffer_window;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int NL = 3;
    localparam int AW = $clog2(LW);

    logic             clk;
    logic             rst_n;
    logic             i_valid;
    logic             i_sof;
    logic             i_eol;
    logic [DW-1:0]    i_data;
    logic             o_valid;
    logic [NL*DW-1:0] o_col;
    logic             o_col_full;
    logic [AW-1:0]    o_x;
    logic [15:0]      o_y;
    logic             o_ovf;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    line_buffer_window #(
        .DATA_WIDTH (DW),
        .LINE_WIDTH (LW),
        .NUM_LINES  (NL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_sof      (i_sof),
        .i_eol      (i_eol),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_col      (o_col),
        .o_col_full (o_col_full),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_ovf      (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel, check the column one cycle later, optionally insert an idle cycle.
    task automatic px(input string tag, input logic [7:0] d, input bit sof, input bit eol,
                      input logic [23:0] e_col, input bit e_full, input int e_x, input int e_y,
                      input bit e_ovf, input bit gap);
        string t;
        @(negedge clk);
        i_valid = 1'b1;
        i_sof   = sof;
        i_eol   = eol;
        i_data  = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eol   = 1'b0;
        t = $sformatf("%s y%0d x%0d", tag, e_y, e_x);
        check({t, " valid"}, 64'(o_valid), 64'(1));
        check({t, " col"},   64'(o_col), 64'(e_col));
        check({t, " full"},  64'(o_col_full), 64'(e_full));
        check({t, " x"},     64'(o_x), 64'(e_x));
        check({t, " y"},     64'(o_y), 64'(e_y));
        check({t, " ovf"},   64'(o_ovf), 64'(e_ovf));
        if (gap) begin
            @(posedge clk);
            #1;
            check({t, " idle valid"}, 64'(o_valid), 64'(0));
            check({t, " idle full"},  64'(o_col_full), 64'(0));
            check({t, " idle hold"},  64'(o_col), 64'(e_col));
        end
    endtask

    // Send 8 pixels of frame line y; rows = number of earlier lines present in the frame.
    task automatic send_line(input string tag, input int y, input int rows, input bit sof_first,
                             input bit gap, input bit do_eol, input bit e_ovf);
        for (int x = 0; x < LW; x++) begin
            logic [7:0] l0;
            logic [7:0] l1;
            logic [7:0] l2;
            l0 = 8'(16 * y + x);
            l1 = (rows >= 1) ? 8'(16 * (y - 1) + x) : 8'h00;
            l2 = (rows >= 2) ? 8'(16 * (y - 2) + x) : 8'h00;
            px(tag, l0, sof_first && (x == 0), do_eol && (x == LW - 1),
               {l2, l1, l0}, rows >= 2, x, y, e_ovf, gap);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, 64'(o_valid), 64'(0));
        check({tag, " col"},   64'(o_col), 64'(0));
        check({tag, " full"},  64'(o_col_full), 64'(0));
        check({tag, " x"},     64'(o_x), 64'(0));
        check({tag, " y"},     64'(o_y), 64'(0));
        check({tag, " ovf"},   64'(o_ovf), 64'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eol   = 1'b0;
        i_data  = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: first frame, three lines, edge masking then full columns.
        send_line("s1", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_line("s1", 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_line("s1", 2, 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // 2: five lines, slot pointer wraps twice.
        send_line("s2", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int y = 1; y < 5; y++) begin
            send_line("s2", y, (y > 2) ? 2 : y, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // 3: same frame as 1 with an idle cycle after every pixel.
        send_line("s3", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_line("s3", 1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_line("s3", 2, 2, 1'b0, 1'b1, 1'b1, 1'b0);

        // 4: line 1 runs past LINE_WIDTH; overflow pixels must not touch the RAM.
        send_line("s4", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_line("s4", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        px("s4 ovf9",  8'h18, 1'b0, 1'b0, 24'h000018, 1'b0, 7, 1, 1'b1, 1'b0);
        px("s4 ovf10", 8'h19, 1'b0, 1'b1, 24'h000019, 1'b0, 7, 1, 1'b1, 1'b0);
        send_line("s4", 2, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        px("s4 sof", 8'h00, 1'b1, 1'b0, 24'h000000, 1'b0, 0, 0, 1'b0, 1'b0);

        // 5: new frame starts after two lines; older lines must be masked.
        send_line("s5", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_line("s5", 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_line("s5b", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_line("s5b", 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);

        // 6: reset in the middle of line 1, then a fresh frame.
        send_line("s6", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int x = 0; x < 3; x++) begin
            px("s6 part", 8'(16 + x), 1'b0, 1'b0, {8'h00, 8'(x), 8'(16 + x)},
               1'b0, x, 1, 1'b0, 1'b0);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("s6 in reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_line("s6 new", 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_line("s6 new", 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_line("s6 new", 2, 2, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
